lpupf_pipe_adder_pwr: RTL and testbench
=======================================

Name: lpupf_pipe_adder_pwr

Overview:
- Parametrised, pipelined successor to the single-bit latched full-adder/XOR-AND blocks.
- WIDTH-bit adder split across NUM_DOM registered stages. Each stage models one switchable power domain slice.
- Integrated power sequencer drains the pipe, then drives isolate, save, power-off, power-up, restore and de-isolate through a request/acknowledge handshake.
- Sits under the low-power top, between operand sources and result consumers, and exports control strobes for UPF isolation/retention cells.

Parameters:
- WIDTH, 8: operand/sum width. Must be divisible by NUM_DOM.
- NUM_DOM, 4: pipeline stages / power slices. CHUNK = WIDTH/NUM_DOM bits per stage.
- PWRUP_CYC, 3: cycles spent in PWRUP waiting for rail settle (>=1).
- CNT_W, 16: width of completed-operation counter.

Ports:
- clk_upf  in  1  single clock, all flops rising-edge
- rst_upf_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  result valid (one-cycle pulse per beat, no backpressure)
- out_sum  out  WIDTH  a+b+cin, low WIDTH bits
- out_cout  out  1  carry out of MSB
- out_xor  out  WIDTH  a^b, delayed to align with out_sum
- out_and  out  WIDTH  a&b, delayed to align with out_sum
- op_cnt  out  CNT_W  number of results emitted, wraps at 2^CNT_W
- pwr_down_req  in  1  request power-down
- pwr_up_req  in  1  request power-up
- pwr_ack  out  1  one-cycle pulse when a down or up sequence completes
- iso_en  out  1  isolation enable
- save  out  1  retention save strobe
- restore  out  1  retention restore strobe
- pwr_en  out  1  domain power switch enable
- pwr_state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst_upf_n=0 at an edge):
  - All pipeline registers, valids and op_cnt go to 0.
  - FSM goes to ON; pwr_en=1, iso_en=0, save=0, restore=0, pwr_ack=0, in_ready=1.
  - Reset mid-sequence aborts the sequence and returns to ON, powered and de-isolated.
- Datapath:
  - A beat is accepted when in_valid & in_ready.
  - Stage k (0..NUM_DOM-1) adds bits [k*CHUNK +: CHUNK] with the carry registered from stage k-1. Stage 0 uses in_cin.
  - Higher operand bits are skewed forward through the registers.
  - Latency is exactly NUM_DOM cycles: a beat accepted at edge t gives out_valid=1 in the cycle after edge t+NUM_DOM-1.
  - Full throughput of one beat per cycle.
  - out_xor/out_and are carried in the same pipeline so they are aligned with out_sum.
  - When out_valid=0, the data outputs hold their last value.
- op_cnt increments by 1 on every out_valid cycle and wraps from all-ones to 0.
- FSM states (encoding 0..7):
  - ON: in_ready=1. On pwr_down_req go to DRAIN. A beat presented in the same cycle is still accepted. If pwr_down_req and pwr_up_req are both high, down wins. pwr_up_req is ignored.
  - DRAIN: in_ready=0. Stay until all stage valids are 0, then go to ISO. If already empty, leave after 1 cycle.
  - ISO: iso_en=1, 1 cycle, then SAVE.
  - SAVE: save=1 for 1 cycle, iso_en=1, then OFF.
  - OFF: pwr_en=0, iso_en=1, pwr_ack=1 on the entry cycle only.
    - Pipeline registers are cleared while in OFF, modelling loss of state.
    - On pwr_up_req go to PWRUP; pwr_down_req is ignored.
  - PWRUP: pwr_en=1, iso_en=1. A counter runs PWRUP_CYC cycles, then goes to RESTORE.
  - RESTORE: restore=1 for 1 cycle, iso_en=1, then UNISO.
  - UNISO: iso_en=0, pwr_ack=1 for 1 cycle, then ON. in_ready=0 during this cycle.
- Isolation clamp: while iso_en=1, out_valid, out_sum, out_cout, out_xor and out_and read as 0. op_cnt is not clamped (always-on).
- in_ready=0 in every state except ON.

Optional Feature:
- Macro LPUPF_OP_CNT_RETENTION_EN.
- Defined: op_cnt is copied into a shadow register on save and reloaded on restore, so its value survives OFF.
- Undefined: op_cnt is cleared to 0 while in OFF and reads 0 after power-up. No shadow register is built.

Test Plan:
- Carry ripple, defaults: reset, then a=8'hFF, b=8'h01, cin=0 -> exactly 4 cycles later out_valid=1, out_sum=8'h00, out_cout=1, out_xor=8'hFE, out_and=8'h01.
- Back-to-back: 5 consecutive beats (3+4+1, 8'h80+8'h80+0, 0+0+1, 8'h55+8'hAA+0, 8'h0F+8'h01+0) -> 5 contiguous out_valid pulses with sums 08, 00/cout1, 01, FF, 10; op_cnt=5.
- Power-down with pipe busy: 2 beats in flight, then assert pwr_down_req -> both results emitted before iso_en rises; ISO, SAVE and OFF follow with the 1-cycle strobes; pwr_ack pulses on OFF entry; in_ready=0 throughout.
- Power-up: from OFF assert pwr_up_req -> pwr_en=1, then PWRUP for 3 cycles, then restore pulse, then UNISO with pwr_ack; in_ready=1 on the next cycle; a new beat 2+2 gives sum 4.
- Retention: op_cnt=5, then a full down/up sequence -> op_cnt=5 with LPUPF_OP_CNT_RETENTION_EN defined, 0 without.
- Reset mid-sequence: drop rst_upf_n during PWRUP -> next cycle state=ON, pwr_en=1, iso_en=0, op_cnt=0, in_ready=1.

Source files
------------

// File: rtl/lpupf_pipe_adder_pwr.sv
// Pipelined WIDTH-bit adder in NUM_DOM power slices, with a drain /
// isolate / save / off / power-up / restore / de-isolate power sequencer.
//
// Ports:
//   clk_upf, rst_upf_n      clock, synchronous active-low reset
//   in_valid/in_ready       operand beat handshake
//   in_a, in_b, in_cin      operands and carry-in
//   out_valid               one-cycle pulse per result (no backpressure)
//   out_sum, out_cout       a+b+cin and carry out of the MSB
//   out_xor, out_and        a^b and a&b, aligned with out_sum
//   op_cnt                  results emitted, wraps at 2^CNT_W
//   pwr_down_req/pwr_up_req power sequencing requests
//   pwr_ack                 pulse when a down or up sequence completes
//   iso_en, save, restore   strobes for UPF isolation/retention cells
//   pwr_en                  domain power switch enable
//   pwr_state               FSM state encoding (debug)
//
// Optional build macro: LPUPF_OP_CNT_RETENTION_EN keeps op_cnt across
// OFF via a shadow register; without it op_cnt restarts at 0.

module lpupf_pipe_adder_pwr #(
    parameter int WIDTH     = 8,
    parameter int NUM_DOM   = 4,
    parameter int PWRUP_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_upf,
    input  logic             rst_upf_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [WIDTH-1:0] out_xor,
    output logic [WIDTH-1:0] out_and,
    output logic [CNT_W-1:0] op_cnt,
    input  logic             pwr_down_req,
    input  logic             pwr_up_req,
    output logic             pwr_ack,
    output logic             iso_en,
    output logic             save,
    output logic             restore,
    output logic             pwr_en,
    output logic [2:0]       pwr_state
);

    localparam int CHUNK = WIDTH / NUM_DOM;
    localparam int LAST  = NUM_DOM - 1;
    localparam int PCW   = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
    localparam logic [PCW-1:0] PWRUP_LAST = PCW'(PWRUP_CYC - 1);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISO     = 3'd2,
        ST_SAVE    = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWRUP   = 3'd5,
        ST_RESTORE = 3'd6,
        ST_UNISO   = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic           r_off_entry;
    logic [PCW-1:0] r_pcnt;

    // Per-stage registers. Full-width operand copies carry the upper
    // chunks forward; each stage only consumes its own chunk.
    logic [WIDTH-1:0]   r_a [NUM_DOM];
    logic [WIDTH-1:0]   r_b [NUM_DOM];
    logic [WIDTH-1:0]   r_s [NUM_DOM];
    logic [WIDTH-1:0]   r_x [NUM_DOM];
    logic [WIDTH-1:0]   r_n [NUM_DOM];
    logic [NUM_DOM-1:0] r_c;
    logic [NUM_DOM-1:0] r_v;

    logic [WIDTH-1:0] w_ai  [NUM_DOM];
    logic [WIDTH-1:0] w_bi  [NUM_DOM];
    logic [WIDTH-1:0] w_si  [NUM_DOM];
    logic [WIDTH-1:0] w_xi  [NUM_DOM];
    logic [WIDTH-1:0] w_ni  [NUM_DOM];
    logic             w_ci  [NUM_DOM];
    logic             w_vi  [NUM_DOM];
    logic [WIDTH-1:0] w_so  [NUM_DOM];
    logic             w_co  [NUM_DOM];
    logic [CHUNK:0]   w_add [NUM_DOM];

    logic             w_acc;
    logic             w_empty;
    logic [CNT_W-1:0] r_op_cnt;

    assign w_acc   = in_valid & in_ready;
    assign w_empty = ~|r_v;

    // Stage inputs: stage 0 from the ports, stage k from stage k-1.
    always_comb begin : p_stage_in
        w_ai[0] = in_a;
        w_bi[0] = in_b;
        w_si[0] = '0;
        w_xi[0] = in_a ^ in_b;
        w_ni[0] = in_a & in_b;
        w_ci[0] = in_cin;
        w_vi[0] = w_acc;
        for (int k = 1; k < NUM_DOM; k++) begin
            w_ai[k] = r_a[k-1];
            w_bi[k] = r_b[k-1];
            w_si[k] = r_s[k-1];
            w_xi[k] = r_x[k-1];
            w_ni[k] = r_n[k-1];
            w_ci[k] = r_c[k-1];
            w_vi[k] = r_v[k-1];
        end
    end

    // Chunk adders: stage k fills sum bits [k*CHUNK +: CHUNK].
    always_comb begin : p_stage_add
        for (int k = 0; k < NUM_DOM; k++) begin
            w_add[k] = {1'b0, w_ai[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_bi[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_ci[k]};
            w_so[k] = w_si[k];
            w_so[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
            w_co[k] = w_add[k][CHUNK];
        end
    end

    // Data only loads with a valid beat so the outputs hold between
    // results. OFF wipes the slices to model loss of state.
    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n || r_state == ST_OFF) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < NUM_DOM; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_x[k] <= '0;
                r_n[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DOM; k++) begin
                r_v[k] <= w_vi[k];
                if (w_vi[k]) begin
                    r_a[k] <= w_ai[k];
                    r_b[k] <= w_bi[k];
                    r_s[k] <= w_so[k];
                    r_x[k] <= w_xi[k];
                    r_n[k] <= w_ni[k];
                    r_c[k] <= w_co[k];
                end
            end
        end
    end

    // Isolation clamp on everything leaving the switchable slices.
    assign out_valid = r_v[LAST] & ~iso_en;
    assign out_sum   = iso_en ? '0 : r_s[LAST];
    assign out_cout  = iso_en ? 1'b0 : r_c[LAST];
    assign out_xor   = iso_en ? '0 : r_x[LAST];
    assign out_and   = iso_en ? '0 : r_n[LAST];

    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_state <= ST_ON;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // OFF is only ever entered from SAVE, so this flags its first cycle.
    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_off_entry <= 1'b0;
        end else begin
            r_off_entry <= (r_state == ST_SAVE);
        end
    end

    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_pcnt <= '0;
        end else if (r_state == ST_PWRUP) begin
            r_pcnt <= r_pcnt + 1'b1;
        end else begin
            r_pcnt <= '0;
        end
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        iso_en      = 1'b0;
        save        = 1'b0;
        restore     = 1'b0;
        pwr_en      = 1'b1;
        pwr_ack     = 1'b0;
        unique case (r_state)
            ST_ON: begin
                in_ready = 1'b1;
                if (pwr_down_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_ISO;
                end
            end
            ST_ISO: begin
                iso_en      = 1'b1;
                w_state_nxt = ST_SAVE;
            end
            ST_SAVE: begin
                iso_en      = 1'b1;
                save        = 1'b1;
                w_state_nxt = ST_OFF;
            end
            ST_OFF: begin
                iso_en  = 1'b1;
                pwr_en  = 1'b0;
                pwr_ack = r_off_entry;
                if (pwr_up_req) begin
                    w_state_nxt = ST_PWRUP;
                end
            end
            ST_PWRUP: begin
                iso_en = 1'b1;
                if (r_pcnt == PWRUP_LAST) begin
                    w_state_nxt = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                iso_en      = 1'b1;
                restore     = 1'b1;
                w_state_nxt = ST_UNISO;
            end
            ST_UNISO: begin
                pwr_ack     = 1'b1;
                w_state_nxt = ST_ON;
            end
            default: begin
                w_state_nxt = ST_ON;
            end
        endcase
    end

    assign pwr_state = r_state;

`ifdef LPUPF_OP_CNT_RETENTION_EN
    logic [CNT_W-1:0] r_op_shadow;

    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_op_shadow <= '0;
        end else if (r_state == ST_SAVE) begin
            r_op_shadow <= r_op_cnt;
        end
    end

    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_op_cnt <= '0;
        end else if (r_state == ST_RESTORE) begin
            r_op_cnt <= r_op_shadow;
        end else if (r_state == ST_OFF) begin
            r_op_cnt <= '0;
        end else if (out_valid) begin
            r_op_cnt <= r_op_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk_upf) begin
        if (!rst_upf_n) begin
            r_op_cnt <= '0;
        end else if (r_state == ST_OFF) begin
            r_op_cnt <= '0;
        end else if (out_valid) begin
            r_op_cnt <= r_op_cnt + 1'b1;
        end
    end
`endif

    assign op_cnt = r_op_cnt;

endmodule

// File: tb/tb_lpupf_pipe_adder_pwr.sv
// Scoreboard bench for lpupf_pipe_adder_pwr: directed beats and
// power-down / power-up / reset-abort sequences.

module tb_lpupf_pipe_adder_pwr;

    localparam int ND = 4;

    logic        clk_upf = 1'b0;
    logic        rst_upf_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_cin;
    logic        out_valid;
    logic [7:0]  out_sum;
    logic        out_cout;
    logic [7:0]  out_xor;
    logic [7:0]  out_and;
    logic [15:0] op_cnt;
    logic        pwr_down_req;
    logic        pwr_up_req;
    logic        pwr_ack;
    logic        iso_en;
    logic        save;
    logic        restore;
    logic        pwr_en;
    logic [2:0]  pwr_state;

    always #5 clk_upf = ~clk_upf;

    lpupf_pipe_adder_pwr #(
        .WIDTH(8), .NUM_DOM(ND), .PWRUP_CYC(3), .CNT_W(16)
    ) dut (
        .clk_upf(clk_upf), .rst_upf_n(rst_upf_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_sum(out_sum),
        .out_cout(out_cout), .out_xor(out_xor),
        .out_and(out_and), .op_cnt(op_cnt),
        .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
        .pwr_ack(pwr_ack), .iso_en(iso_en), .save(save),
        .restore(restore), .pwr_en(pwr_en),
        .pwr_state(pwr_state)
    );

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic [7:0] x;
        logic [7:0] n;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n;
    bit   bad_rdy;
    bit   bad_iso;
    int   exp_cnt;

    always @(posedge clk_upf) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest pending beat,
    // including the cycle it was due on.
    always @(negedge clk_upf) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got sum %0h, want no result",
                         out_sum);
            end else begin
                m_e = q.pop_front();
                chk("sb_sum", 32'(out_sum), 32'(m_e.s));
                chk("sb_cout", 32'(out_cout), 32'(m_e.c));
                chk("sb_xor", 32'(out_xor), 32'(m_e.x));
                chk("sb_and", 32'(out_and), 32'(m_e.n));
                chk("sb_cycle", 32'(cyc), 32'(m_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    // Called at a negedge; the beat is taken at the next posedge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es,
                        input logic ec, input logic [7:0] ex,
                        input logic [7:0] en);
        exp_t e;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = ci;
        e.s = es;
        e.c = ec;
        e.x = ex;
        e.n = en;
        e.cyc = cyc + ND;
        q.push_back(e);
        @(negedge clk_upf);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_upf_n = 1'b0;
        repeat (2) @(negedge clk_upf);
        rst_upf_n = 1'b1;
    endtask

    initial begin
        rst_upf_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        pwr_down_req = 1'b0;
        pwr_up_req = 1'b0;
        repeat (2) @(negedge clk_upf);
        chk("rst_state", 32'(pwr_state), 32'd0);
        chk("rst_pwr_en", 32'(pwr_en), 32'd1);
        chk("rst_iso", 32'(iso_en), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("rst_ack", 32'(pwr_ack), 32'd0);
        rst_upf_n = 1'b1;
        @(negedge clk_upf);

        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE, 8'h01);
        repeat (6) @(negedge clk_upf);
        chk("ripple_op_cnt", 32'(op_cnt), 32'd1);

        do_reset();
        chk("rst2_op_cnt", 32'(op_cnt), 32'd0);

        send(8'h03, 8'h04, 1'b1, 8'h08, 1'b0, 8'h07, 8'h00);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 8'h80);
        send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
        send(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 8'hFF, 8'h00);
        send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h0E, 8'h01);
        repeat (6) @(negedge clk_upf);
        chk("b2b_op_cnt", 32'(op_cnt), 32'd5);
        chk("b2b_drained", 32'(q.size()), 32'd0);

        // Power down with two beats in flight.
        send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h26, 8'h10);
        send(8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 8'hD0, 8'h20);
        pwr_down_req = 1'b1;
        @(negedge clk_upf);
        pwr_down_req = 1'b0;
        chk("dn_drain", 32'(pwr_state), 32'd1);
        bad_rdy = 1'b0;
        bad_iso = 1'b0;
        n = 0;
        while (pwr_state == 3'd1 && n < 20) begin
            if (in_ready) bad_rdy = 1'b1;
            if (iso_en) bad_iso = 1'b1;
            n++;
            @(negedge clk_upf);
        end
        chk("dn_drain_ready", 32'(bad_rdy), 32'd0);
        chk("dn_drain_iso", 32'(bad_iso), 32'd0);
        chk("dn_iso_state", 32'(pwr_state), 32'd2);
        chk("dn_iso_en", 32'(iso_en), 32'd1);
        chk("dn_iso_pending", 32'(q.size()), 32'd0);
        chk("dn_iso_save", 32'(save), 32'd0);
        chk("dn_iso_ready", 32'(in_ready), 32'd0);
        @(negedge clk_upf);
        chk("dn_save_state", 32'(pwr_state), 32'd3);
        chk("dn_save", 32'(save), 32'd1);
        chk("dn_save_iso", 32'(iso_en), 32'd1);
        @(negedge clk_upf);
        chk("dn_off_state", 32'(pwr_state), 32'd4);
        chk("dn_off_save", 32'(save), 32'd0);
        chk("dn_off_pwr_en", 32'(pwr_en), 32'd0);
        chk("dn_off_ack", 32'(pwr_ack), 32'd1);
        chk("dn_off_iso", 32'(iso_en), 32'd1);
        chk("dn_off_ready", 32'(in_ready), 32'd0);
        @(negedge clk_upf);
        chk("dn_off_ack2", 32'(pwr_ack), 32'd0);
        chk("dn_off_stay", 32'(pwr_state), 32'd4);
        chk("dn_off_sum", 32'(out_sum), 32'd0);

        // Power up.
        pwr_up_req = 1'b1;
        @(negedge clk_upf);
        pwr_up_req = 1'b0;
        chk("up_state", 32'(pwr_state), 32'd5);
        chk("up_pwr_en", 32'(pwr_en), 32'd1);
        chk("up_iso", 32'(iso_en), 32'd1);
        n = 0;
        while (pwr_state == 3'd5 && n < 20) begin
            n++;
            @(negedge clk_upf);
        end
        chk("up_pwrup_cycles", 32'(n), 32'd3);
        chk("up_restore_state", 32'(pwr_state), 32'd6);
        chk("up_restore", 32'(restore), 32'd1);
        chk("up_restore_iso", 32'(iso_en), 32'd1);
        @(negedge clk_upf);
        chk("up_uniso_state", 32'(pwr_state), 32'd7);
        chk("up_uniso_restore", 32'(restore), 32'd0);
        chk("up_uniso_ack", 32'(pwr_ack), 32'd1);
        chk("up_uniso_iso", 32'(iso_en), 32'd0);
        chk("up_uniso_ready", 32'(in_ready), 32'd0);
        @(negedge clk_upf);
        chk("up_on_state", 32'(pwr_state), 32'd0);
        chk("up_on_ready", 32'(in_ready), 32'd1);
        chk("up_on_ack", 32'(pwr_ack), 32'd0);
`ifdef LPUPF_OP_CNT_RETENTION_EN
        exp_cnt = 7;
`else
        exp_cnt = 0;
`endif
        chk("ret_op_cnt", 32'(op_cnt), 32'(exp_cnt));

        send(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 8'h00, 8'h02);
        repeat (5) @(negedge clk_upf);
        chk("post_up_op_cnt", 32'(op_cnt), 32'(exp_cnt + 1));

        // Both requests together: down wins; empty pipe drains in 1.
        pwr_down_req = 1'b1;
        pwr_up_req = 1'b1;
        @(negedge clk_upf);
        pwr_down_req = 1'b0;
        pwr_up_req = 1'b0;
        chk("both_req_drain", 32'(pwr_state), 32'd1);
        @(negedge clk_upf);
        chk("empty_drain_iso", 32'(pwr_state), 32'd2);
        n = 0;
        while (pwr_state != 3'd4 && n < 20) begin
            n++;
            @(negedge clk_upf);
        end
        chk("abort_off", 32'(pwr_state), 32'd4);
        pwr_up_req = 1'b1;
        @(negedge clk_upf);
        pwr_up_req = 1'b0;
        chk("abort_pwrup", 32'(pwr_state), 32'd5);
        @(negedge clk_upf);
        rst_upf_n = 1'b0;
        @(negedge clk_upf);
        chk("abort_state", 32'(pwr_state), 32'd0);
        chk("abort_pwr_en", 32'(pwr_en), 32'd1);
        chk("abort_iso", 32'(iso_en), 32'd0);
        chk("abort_op_cnt", 32'(op_cnt), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        rst_upf_n = 1'b1;
        repeat (2) @(negedge clk_upf);
        chk("end_pending", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
